// File: rtl/datapath_unit_if.sv
// ============================================================================
//  Module      : datapath_unit_if
//  Description : Memory bus between the datapath and an asynchronous-read
//                memory. The datapath drives address, write data and write
//                enable; the memory returns read data for the current address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface datapath_unit_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/datapath_unit.sv
// ============================================================================
//  Module      : datapath_unit
//  Description : Register-transfer datapath executing single-cycle
//                micro-commands from the CPU control unit. Holds PC, SP, IR,
//                MA, MD, A, AP, R, the Z/C flags, an 8-bit ALU, the memory
//                port and the IN/OUT ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_unit #(
    parameter logic [7:0] PC_INIT = 8'h00,
    parameter logic [7:0] SP_INIT = 8'hFF
) (
    input  wire logic          i_clk,
    input  wire logic          i_rstn,
    input  wire logic [3:0]    i_transfer_cmd,
    input  wire logic          i_inc_pc,
    input  wire logic [1:0]    i_inc_dec_sp,
    input  wire logic          i_alu_calculate,
    input  wire logic          i_sel_ap,
    input  wire logic          i_reset_ir,
    datapath_unit_if.master    mem,
    input  wire logic [7:0]    i_in,
    output logic      [7:0]    o_out,
    output logic               o_out_valid,
    output logic      [7:0]    o_ir,
    output logic               o_flag_z,
    output logic               o_flag_c
);

    // Micro-command encoding
    localparam logic [3:0] c_cmd_ma_pc    = 4'h1;
    localparam logic [3:0] c_cmd_md_mem   = 4'h2;
    localparam logic [3:0] c_cmd_ir_md    = 4'h3;
    localparam logic [3:0] c_cmd_ma_md    = 4'h4;
    localparam logic [3:0] c_cmd_acc_md   = 4'h5;
    localparam logic [3:0] c_cmd_ma_ap    = 4'h6;
    localparam logic [3:0] c_cmd_ma_sp    = 4'h7;
    localparam logic [3:0] c_cmd_md_acc   = 4'h8;
    localparam logic [3:0] c_cmd_mem_wr   = 4'h9;
    localparam logic [3:0] c_cmd_acc_r    = 4'hA;
    localparam logic [3:0] c_cmd_jump     = 4'hB;
    localparam logic [3:0] c_cmd_a_in     = 4'hC;
    localparam logic [3:0] c_cmd_out_a    = 4'hD;
    localparam logic [3:0] c_cmd_pc_ap    = 4'hE;
    localparam logic [3:0] c_cmd_md_pc    = 4'hF;

    // ALU operation selected by IR[7:4]
    localparam logic [3:0] c_alu_add = 4'h3;
    localparam logic [3:0] c_alu_sub = 4'h4;
    localparam logic [3:0] c_alu_not = 4'h5;
    localparam logic [3:0] c_alu_and = 4'h6;
    localparam logic [3:0] c_alu_or  = 4'h7;
    localparam logic [3:0] c_alu_xor = 4'h8;
    localparam logic [3:0] c_alu_shl = 4'h9;

    // Conditional-jump opcodes
    localparam logic [7:0] c_op_jz = 8'hA5;
    localparam logic [7:0] c_op_jc = 8'hA9;

    logic [7:0] pc_q, pc_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] ma_q, ma_d;
    logic [7:0] md_q, md_d;
    logic [7:0] a_q,  a_d;
    logic [7:0] ap_q, ap_d;
    logic [7:0] r_q,  r_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       z_q, z_d;
    logic       c_q, c_d;

    logic [8:0] w_alu_wide;
    logic [7:0] w_alu_res;
    logic       w_alu_c;
    logic       w_jump;

    // ALU: always operates on A and MD; pass-through opcodes clear C like the logic ops
    always_comb begin
        w_alu_wide = 9'h000;
        w_alu_res  = a_q;
        w_alu_c    = 1'b0;
        case (ir_q[7:4])
            c_alu_add: begin
                w_alu_wide = {1'b0, a_q} + {1'b0, md_q};
                w_alu_res  = w_alu_wide[7:0];
                w_alu_c    = w_alu_wide[8];
            end
            c_alu_sub: begin
                // bit 8 of the 9-bit difference is the borrow (A < MD)
                w_alu_wide = {1'b0, a_q} - {1'b0, md_q};
                w_alu_res  = w_alu_wide[7:0];
                w_alu_c    = w_alu_wide[8];
            end
            c_alu_not: w_alu_res = ~a_q;
            c_alu_and: w_alu_res = a_q & md_q;
            c_alu_or:  w_alu_res = a_q | md_q;
            c_alu_xor: w_alu_res = a_q ^ md_q;
            c_alu_shl: begin
                w_alu_res = {a_q[6:0], 1'b0};
                w_alu_c   = a_q[7];
            end
            default: w_alu_res = a_q;
        endcase
    end

    // Jump condition from the current IR and the flags registered before this edge
    always_comb begin
        case (ir_q)
            c_op_jz: w_jump = z_q;
            c_op_jc: w_jump = c_q;
            default: w_jump = 1'b1;
        endcase
    end

    // Next-state decode of the micro-command and the side-band controls
    always_comb begin
        pc_d        = i_inc_pc ? pc_q + 8'd1 : pc_q;
        sp_d        = sp_q;
        ir_d        = ir_q;
        ma_d        = ma_q;
        md_d        = md_q;
        a_d         = a_q;
        ap_d        = ap_q;
        r_d         = r_q;
        out_d       = out_q;
        out_valid_d = (i_transfer_cmd == c_cmd_out_a);
        z_d         = z_q;
        c_d         = c_q;

        case (i_transfer_cmd)
            c_cmd_ma_pc:  ma_d = pc_q;
            c_cmd_md_mem: md_d = mem.mem_rdata;
            c_cmd_ir_md:  ir_d = md_q;
            c_cmd_ma_md:  ma_d = md_q;
            c_cmd_acc_md: begin
                if (i_sel_ap) ap_d = md_q;
                else          a_d  = md_q;
            end
            c_cmd_ma_ap:  ma_d = ap_q;
            c_cmd_ma_sp:  ma_d = sp_q;
            c_cmd_md_acc: md_d = i_sel_ap ? ap_q : a_q;
            c_cmd_acc_r: begin
                if (i_sel_ap) ap_d = r_q;
                else          a_d  = r_q;
            end
            // a taken jump replaces any PC increment requested this cycle
            c_cmd_jump:   if (w_jump) pc_d = md_q;
            c_cmd_a_in:   a_d   = i_in;
            c_cmd_out_a:  out_d = a_q;
            c_cmd_pc_ap:  pc_d  = ap_q;
            c_cmd_md_pc:  md_d  = pc_q;
            default: ;
        endcase

        if (i_reset_ir) ir_d = 8'h00;

        case (i_inc_dec_sp)
            2'b01:   sp_d = sp_q + 8'd1;
            2'b10:   sp_d = sp_q - 8'd1;
            default: sp_d = sp_q;
        endcase

        if (i_alu_calculate) begin
            r_d = w_alu_res;
            z_d = (w_alu_res == 8'h00);
            c_d = w_alu_c;
        end
    end

    // Architectural register file with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc_q        <= PC_INIT;
            sp_q        <= SP_INIT;
            ir_q        <= 8'h00;
            ma_q        <= 8'h00;
            md_q        <= 8'h00;
            a_q         <= 8'h00;
            ap_q        <= 8'h00;
            r_q         <= 8'h00;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            ir_q        <= ir_d;
            ma_q        <= ma_d;
            md_q        <= md_d;
            a_q         <= a_d;
            ap_q        <= ap_d;
            r_q         <= r_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            c_q         <= c_d;
        end
    end

    // Write enable is gated by reset so an in-flight write is dropped at once
    assign mem.mem_we    = i_rstn & (i_transfer_cmd == c_cmd_mem_wr);
    assign mem.mem_addr  = ma_q;
    assign mem.mem_wdata = md_q;
    assign o_out         = out_q;
    assign o_out_valid   = out_valid_q;
    assign o_ir          = ir_q;
    assign o_flag_z      = z_q;
    assign o_flag_c      = c_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_unit.sv
// ============================================================================
//  Module      : tb_datapath_unit
//  Description : Self-checking bench for datapath_unit. A behavioural model
//                predicts the visible state; expectations are queued when
//                stimulus is issued and popped by a monitor on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_unit;

    localparam logic [7:0] PC_INIT = 8'h10;
    localparam logic [7:0] SP_INIT = 8'hFF;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] i_transfer_cmd;
    logic       i_inc_pc;
    logic [1:0] i_inc_dec_sp;
    logic       i_alu_calculate;
    logic       i_sel_ap;
    logic       i_reset_ir;
    logic [7:0] i_in;
    logic [7:0] o_out;
    logic       o_out_valid;
    logic [7:0] o_ir;
    logic       o_flag_z;
    logic       o_flag_c;

    logic [7:0] mem [256];

    datapath_unit_if mem_if ();

    assign mem_if.mem_rdata = mem[mem_if.mem_addr];

    always #5 clk = ~clk;

    datapath_unit #(
        .PC_INIT(PC_INIT),
        .SP_INIT(SP_INIT)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_transfer_cmd (i_transfer_cmd),
        .i_inc_pc       (i_inc_pc),
        .i_inc_dec_sp   (i_inc_dec_sp),
        .i_alu_calculate(i_alu_calculate),
        .i_sel_ap       (i_sel_ap),
        .i_reset_ir     (i_reset_ir),
        .mem            (mem_if.master),
        .i_in           (i_in),
        .o_out          (o_out),
        .o_out_valid    (o_out_valid),
        .o_ir           (o_ir),
        .o_flag_z       (o_flag_z),
        .o_flag_c       (o_flag_c)
    );

    // Reference model state
    logic [7:0] m_pc, m_sp, m_ir, m_ma, m_md, m_a, m_ap, m_r, m_out;
    logic       m_z, m_c, m_valid;

    // Scoreboard queues
    logic [35:0] snap_q [$];
    logic [15:0] we_q   [$];
    logic [7:0]  out_q  [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] dut_snap();
        return {o_ir, mem_if.mem_addr, mem_if.mem_wdata, o_out,
                o_flag_z, o_flag_c, o_out_valid, mem_if.mem_we};
    endfunction

    task automatic model_reset();
        m_pc = PC_INIT; m_sp = SP_INIT;
        m_ir = 0; m_ma = 0; m_md = 0; m_a = 0; m_ap = 0; m_r = 0; m_out = 0;
        m_z = 0; m_c = 0; m_valid = 0;
    endtask

    // ALU behaviour computed with plain integer arithmetic
    task automatic model_alu(input logic [7:0] a, input logic [7:0] md, input logic [7:0] ir,
                             output logic [7:0] r, output logic z, output logic c);
        int ai, mi, res;
        ai = int'(a); mi = int'(md); c = 1'b0;
        case (ir[7:4])
            4'h3: begin res = ai + mi; c = (res > 255); end
            4'h4: begin res = ai - mi; c = (res < 0);   end
            4'h5: res = 255 - ai;
            4'h6: res = int'(a & md);
            4'h7: res = int'(a | md);
            4'h8: res = int'(a ^ md);
            4'h9: begin res = ai * 2; c = (ai >= 128); end
            default: res = ai;
        endcase
        r = 8'((res + 512) % 256);
        z = (r == 8'h00);
    endtask

    function automatic logic jump_ok(input logic [7:0] ir, input logic z, input logic c);
        if (ir == 8'hA5) return z;
        if (ir == 8'hA9) return c;
        return 1'b1;
    endfunction

    // Issue one command cycle: queue expectations, advance the model, wait for the edge
    task automatic step(input logic [3:0] cmd, input logic inc, input logic [1:0] spm,
                        input logic alu, input logic sel, input logic rir, input logic [7:0] din);
        logic [7:0] n_pc, n_sp, n_ir, n_ma, n_md, n_a, n_ap, n_r, n_out;
        logic       n_z, n_c;
        logic [7:0] ar; logic az, ac;
        i_transfer_cmd  = cmd;
        i_inc_pc        = inc;
        i_inc_dec_sp    = spm;
        i_alu_calculate = alu;
        i_sel_ap        = sel;
        i_reset_ir      = rir;
        i_in            = din;

        snap_q.push_back({m_ir, m_ma, m_md, m_out, m_z, m_c, m_valid, (cmd == 4'h9)});
        if (cmd == 4'h9) we_q.push_back({m_ma, m_md});
        if (cmd == 4'hD) out_q.push_back(m_a);

        n_pc = m_pc; n_sp = m_sp; n_ir = m_ir; n_ma = m_ma; n_md = m_md;
        n_a = m_a; n_ap = m_ap; n_r = m_r; n_out = m_out; n_z = m_z; n_c = m_c;

        if (inc) n_pc = 8'((int'(m_pc) + 1) % 256);
        if (cmd == 4'hB && jump_ok(m_ir, m_z, m_c)) n_pc = m_md;
        if (cmd == 4'hE) n_pc = m_ap;
        if (spm == 2'b01) n_sp = 8'((int'(m_sp) + 1) % 256);
        if (spm == 2'b10) n_sp = 8'((int'(m_sp) + 255) % 256);
        if (cmd == 4'h3) n_ir = m_md;
        if (rir) n_ir = 8'h00;
        if (cmd == 4'h1) n_ma = m_pc;
        if (cmd == 4'h4) n_ma = m_md;
        if (cmd == 4'h6) n_ma = m_ap;
        if (cmd == 4'h7) n_ma = m_sp;
        if (cmd == 4'h2) n_md = mem[m_ma];
        if (cmd == 4'h8) n_md = sel ? m_ap : m_a;
        if (cmd == 4'hF) n_md = m_pc;
        if (cmd == 4'h5) begin if (sel) n_ap = m_md; else n_a = m_md; end
        if (cmd == 4'hA) begin if (sel) n_ap = m_r;  else n_a = m_r;  end
        if (cmd == 4'hC) n_a = din;
        if (cmd == 4'hD) n_out = m_a;
        if (alu) begin
            model_alu(m_a, m_md, m_ir, ar, az, ac);
            n_r = ar; n_z = az; n_c = ac;
        end

        @(posedge clk);
        if (cmd == 4'h9) mem[m_ma] = m_md;
        m_pc = n_pc; m_sp = n_sp; m_ir = n_ir; m_ma = n_ma; m_md = n_md;
        m_a = n_a; m_ap = n_ap; m_r = n_r; m_out = n_out; m_z = n_z; m_c = n_c;
        m_valid = (cmd == 4'hD);
        #1;
    endtask

    task automatic idle(input logic [3:0] cmd);
        step(cmd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compares DUT outputs against queued expectations on each falling edge
    task automatic monitor();
        logic [35:0] exp;
        logic [15:0] wexp;
        logic [7:0]  oexp;
        forever begin
            @(negedge clk);
            if (snap_q.size() != 0) begin
                exp = snap_q.pop_front();
                check("state", dut_snap(), exp);
            end
            if (mem_if.mem_we === 1'b1) begin
                if (we_q.size() == 0) check("mem_we_unexpected", 36'd1, 36'd0);
                else begin
                    wexp = we_q.pop_front();
                    check("mem_write", {20'h0, mem_if.mem_addr, mem_if.mem_wdata}, {20'h0, wexp});
                end
            end
            if (o_out_valid === 1'b1) begin
                if (out_q.size() == 0) check("out_valid_unexpected", 36'd1, 36'd0);
                else begin
                    oexp = out_q.pop_front();
                    check("out_data", {28'h0, o_out}, {28'h0, oexp});
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ops [10];
        ops = '{8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA5, 8'hA9, 8'hB0};
        rstn = 1'b0;
        i_transfer_cmd = 0; i_inc_pc = 0; i_inc_dec_sp = 0; i_alu_calculate = 0;
        i_sel_ap = 0; i_reset_ir = 0; i_in = 0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 0) mem[i] = 8'($urandom);
            else mem[i] = ops[$urandom_range(0, 9)] | ((i % 3 == 0) ? 8'h00 : 8'($urandom_range(0, 15)));
        end
        model_reset();
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_snap(), 36'h0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fetch
        mem[8'h10] = 8'h39;
        mem[8'h11] = 8'h20;
        idle(4'h1);
        check("fetch_addr", {28'h0, mem_if.mem_addr}, {28'h0, 8'h10});
        step(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("fetch_md", {28'h0, mem_if.mem_wdata}, {28'h0, 8'h39});
        idle(4'h3);
        check("fetch_ir", {28'h0, o_ir}, {28'h0, 8'h39});

        // ADD with carry, then carry with zero result
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'hF0);
        idle(4'h1);
        idle(4'h2);
        step(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("add_flags", {34'h0, o_flag_z, o_flag_c}, {34'h0, 2'b01});
        idle(4'hA);
        idle(4'hD);
        check("add_result", {28'h0, o_out}, {28'h0, 8'h10});
        mem[8'h11] = 8'h10;
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'hF0);
        idle(4'h2);
        step(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("add_zero_flags", {34'h0, o_flag_z, o_flag_c}, {34'h0, 2'b11});
        idle(4'hA);
        idle(4'hD);
        check("add_zero_result", {28'h0, o_out}, {28'h0, 8'h00});

        // Conditional jump on Z
        mem[8'h11] = 8'hA5;
        idle(4'h2);
        idle(4'h3);
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h01);
        step(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        mem[8'h11] = 8'h40;
        idle(4'h2);
        step(4'hB, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(4'h1);
        check("jump_not_taken", {28'h0, mem_if.mem_addr}, {28'h0, 8'h12});
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        step(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        step(4'hB, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(4'h1);
        check("jump_taken", {28'h0, mem_if.mem_addr}, {28'h0, 8'h40});

        // Stack wrap, push, pop
        step(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        step(4'h0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(4'h7);
        check("sp_wrap_down", {28'h0, mem_if.mem_addr}, {28'h0, 8'hFF});
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h5A);
        idle(4'h8);
        check("push_data", {28'h0, mem_if.mem_wdata}, {28'h0, 8'h5A});
        idle(4'h9);
        step(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(4'h7);
        check("sp_wrap_up", {28'h0, mem_if.mem_addr}, {28'h0, 8'h00});

        // IN / OUT
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'hC3);
        idle(4'hD);
        check("out_value", {28'h0, o_out}, {28'h0, 8'hC3});
        check("out_valid_high", {35'h0, o_out_valid}, 36'd1);
        idle(4'h0);
        check("out_valid_low", {35'h0, o_out_valid}, 36'd0);

        // Randomized command stream
        repeat (400) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom));
        end
        idle(4'h0);
        idle(4'h0);
        check("queues_drained", 36'(snap_q.size() + we_q.size() + out_q.size()), 36'd0);

        // Asynchronous reset in the middle of a memory write
        i_transfer_cmd = 4'h9;
        #2;
        check("we_before_reset", {35'h0, mem_if.mem_we}, 36'd1);
        rstn = 1'b0;
        #1;
        check("async_reset_state", dut_snap(), 36'h0);
        model_reset();
        @(negedge clk);
        i_transfer_cmd = 4'h0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        idle(4'h1);
        check("pc_after_reset", {28'h0, mem_if.mem_addr}, {28'h0, PC_INIT});
        idle(4'h7);
        check("sp_after_reset", {28'h0, mem_if.mem_addr}, {28'h0, SP_INIT});
        idle(4'h0);
        idle(4'h0);
        check("final_drain", 36'(snap_q.size() + we_q.size() + out_q.size()), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/datapath_unit.md
# datapath_unit

Register-transfer datapath that executes the micro-commands issued by the CPU control unit. It holds the architectural registers PC, SP, IR, MA, MD, A, AP and R, an 8-bit ALU with Z/C flags, the memory port and the IN/OUT ports. It returns the instruction register to the control unit as its opcode input. Each command is single-cycle: the register update happens on the rising edge of the cycle in which the command is presented.

## Interface
- PC_INIT, 8'h00, PC value after reset
- SP_INIT, 8'hFF, SP value after reset
- i_clk  in  1  clock, all state updates on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_transfer_cmd  in  4  micro-command, encoding 0–F in Operation
- i_inc_pc  in  1  PC <= PC+1
- i_inc_dec_sp  in  2  01 = SP+1, 10 = SP-1, 00/11 = hold
- i_alu_calculate  in  1  R <= ALU(A, MD), flags update
- i_sel_ap  in  1  selects AP instead of A for cmds 5, 8, A
- i_reset_ir  in  1  IR <= 8'h00
- i_mem_rdata  in  8  asynchronous-read memory data at o_mem_addr
- o_mem_addr  out  8  = MA
- o_mem_wdata  out  8  = MD
- o_mem_we  out  1  high for exactly the cycle cmd = 9
- i_in  in  8  input port
- o_out  out  8  output register
- o_out_valid  out  1  one-cycle pulse after OUT write
- o_ir  out  8  IR, drives control-unit opcode
- o_flag_z, o_flag_c  out  1 each  flag registers

## Operation
- Commands: 0 none; 1 MA<=PC; 2 MD<=i_mem_rdata; 3 IR<=MD; 4 MA<=MD; 5 A|AP<=MD; 6 MA<=AP; 7 MA<=SP; 8 MD<=A|AP; 9 memory write (o_mem_we=1); A A|AP<=R; B PC<=MD if jump condition holds; C A<=i_in; D o_out<=A; E PC<=AP; F MD<=PC.
- Jump condition for cmd B, decoded from IR: 8'hA1 always; 8'hA5 if Z=1; 8'hA9 if C=1; 8'hB0 (return) always; any other IR always.
- ALU, selected by IR[7:4]: 3 ADD A+MD, C = carry-out; 4 SUB A-MD, C = borrow; 5 NOT A; 6 AND; 7 OR; 8 XOR; 9 SHL A, C = A[7]; other values pass A. Logic ops and NOT clear C. Z = (result==0). R and flags update only when i_alu_calculate=1.
- All arithmetic is 8-bit modulo. PC and SP wrap FF<->00 silently.
- Priority: a PC write from cmd B or E overrides i_inc_pc in the same cycle. i_reset_ir overrides cmd 3. SP inc/dec is independent of any command and may coincide with cmd 5 or cmd 2.
- i_sel_ap is sampled only for cmds 5, 8 and A and is ignored otherwise.
- o_out_valid is registered: it is high for the one cycle after the edge that loaded o_out.

## Timing
- Reset: PC=PC_INIT, SP=SP_INIT. IR, MA, MD, A, AP, R, o_out = 8'h00. Z=0, C=0, o_out_valid=0. Reset asserted mid-instruction aborts immediately, with no partial write.
- o_mem_addr, o_mem_wdata and o_ir are direct register outputs, so a change is visible the cycle after the command.
- o_mem_we is combinational from i_transfer_cmd. Memory captures on the same edge.
- Fetch sequence 1,2(+inc_pc),3 makes IR valid 3 edges after the cmd-1 cycle begins.
- The flags used by cmd B are the values registered before that edge.

## Test plan
- Reset, PC_INIT=8'h10: release reset, then cmd 1 → o_mem_addr=8'h10. Cmd 2 with inc_pc, memory returns 8'h39 → MD=8'h39, PC=8'h11. Cmd 3 → o_ir=8'h39.
- ADD carry: A=8'hF0, MD=8'h20, IR=8'h39, i_alu_calculate=1, then cmd A with i_sel_ap=0 → A=8'h10, C=1, Z=0. Repeat with MD=8'h10 → A=8'h00, C=1, Z=1.
- Conditional jump: IR=8'hA5, MD=8'h40, Z=0, cmd B with i_inc_pc=1 → PC=old+1. Same with Z=1 → PC=8'h40, inc ignored.
- Stack push/pop: SP=8'h00, i_inc_dec_sp=10 → SP=8'hFF. Cmd 7 then cmd 8 with A=8'h5A, then cmd 9 → o_mem_we one cycle, addr FF, wdata 5A. i_inc_dec_sp=01 → SP=8'h00.
- I/O: i_in=8'hC3, cmd C → A=8'hC3. Cmd D → o_out=8'hC3 and o_out_valid high for exactly one cycle.
- Async reset asserted in the middle of cmd 9 → o_mem_we=0 immediately and all registers at their reset values.
